// File: rtl/bus_slave_bridge_pkg.sv
// bus_slave_bridge_pkg
// Shared definitions for the bus slave bridge: default parameter values,
// FSM state encoding and the wait-counter width helper.
package bus_slave_bridge_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Counter must hold values up to TIMEOUT; a zero limit still needs one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/bus_slave_bridge_if.sv
// bus_slave_bridge_if
// Groups the master request/response and the downstream bus request/response.
//   master side : m_select_i, m_we_i, m_addr_i, m_data_i, m_sel_i (request)
//                 m_data_o, m_ack_o, m_err_o                      (response)
//   bus side    : bus_select_o, bus_we_o, bus_addr_o, bus_data_o, bus_sel_o
//                 bus_data_i, bus_ack_i
// Handshake: a master raises m_select_i with a stable request and keeps it
// until it sees m_ack_o (one-cycle pulse, m_err_o qualifies it); it then drops
// select unless it wants a back-to-back transfer. On the bus, bus_select_o
// stays high with stable request fields until a cycle where bus_ack_i=1 (that
// cycle completes the transfer) or the wait limit expires.
// Modport "slave" is the bridge view; "master" is the environment view.
interface bus_slave_bridge_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic              m_select_i;
  logic              m_we_i;
  logic [ADDR_W-1:0] m_addr_i;
  logic [DATA_W-1:0] m_data_i;
  logic [SEL_W-1:0]  m_sel_i;
  logic [DATA_W-1:0] m_data_o;
  logic              m_ack_o;
  logic              m_err_o;

  logic              bus_select_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_data_o;
  logic [SEL_W-1:0]  bus_sel_o;
  logic [DATA_W-1:0] bus_data_i;
  logic              bus_ack_i;

  modport slave (
    input  m_select_i, m_we_i, m_addr_i, m_data_i, m_sel_i,
    output m_data_o, m_ack_o, m_err_o,
    output bus_select_o, bus_we_o, bus_addr_o, bus_data_o, bus_sel_o,
    input  bus_data_i, bus_ack_i
  );

  modport master (
    output m_select_i, m_we_i, m_addr_i, m_data_i, m_sel_i,
    input  m_data_o, m_ack_o, m_err_o,
    input  bus_select_o, bus_we_o, bus_addr_o, bus_data_o, bus_sel_o,
    output bus_data_i, bus_ack_i
  );

endinterface

// File: rtl/bus_slave_bridge_timeout_cnt.sv
// bus_timeout_cnt
// Wait-cycle counter for the bridge BUS state.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clear        : force count to zero (has priority over enable)
//   enable       : count one more waited cycle
//   limit        : wait limit; zero disables expiry
//   expired      : count has reached limit-1 (final allowed wait cycle)
module bus_timeout_cnt #(
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Combinational so the owner can act in the same cycle the count hits the limit.
  assign expired = (limit != '0) && (count_q == (limit - 1'b1));

endmodule

// File: rtl/bus_slave_bridge.sv
// bus_slave_bridge
// Registers a master request onto a downstream bus, waits for the bus ack
// (or a wait-cycle timeout) and returns a one-cycle response to the master.
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-high reset
//   bif       : bus_slave_bridge_if.slave, master request/response and bus signals
//   timeout_o : sticky flag, set by any timeout, cleared only by reset
//   state_o   : current FSM state (debug)
// Latency from accepted select to m_ack_o is k+2 cycles, k = BUS cycles before ack.
module bus_slave_bridge
  import bus_slave_bridge_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,   // multiple of 8
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT   // 0 = wait forever
) (
  input  logic                clk_i,
  input  logic                rst_i,
  bus_slave_bridge_if.slave   bif,
  output logic                timeout_o,
  output state_t              state_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = cnt_width(TIMEOUT);

  state_t state_q, state_d;

  logic              bus_select_q, bus_select_d;
  logic              bus_we_q,     bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q,   bus_addr_d;
  logic [DATA_W-1:0] bus_data_q,   bus_data_d;
  logic [SEL_W-1:0]  bus_sel_q,    bus_sel_d;
  logic [DATA_W-1:0] m_data_q,     m_data_d;
  logic              m_ack_q,      m_ack_d;
  logic              m_err_q,      m_err_d;
  logic              timeout_q,    timeout_d;

  logic in_bus;
  logic expired;

  assign in_bus = (state_q == ST_BUS);

  bus_timeout_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (!in_bus),
    .enable  (in_bus && !bif.bus_ack_i),
    .limit   (CNT_W'(TIMEOUT)),
    .expired (expired)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; select is only looked at in IDLE, ack only in BUS.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bif.m_select_i) state_d = ST_BUS;
      ST_BUS:  if (bif.bus_ack_i || expired) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs. Bus request fields
  // double as the request latch, so they hold until the next accept.
  always_comb begin
    bus_select_d = bus_select_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_data_d   = bus_data_q;
    bus_sel_d    = bus_sel_q;
    m_data_d     = m_data_q;
    m_ack_d      = 1'b0;
    m_err_d      = 1'b0;
    timeout_d    = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (bif.m_select_i) begin
          bus_select_d = 1'b1;
          bus_we_d     = bif.m_we_i;
          bus_addr_d   = bif.m_addr_i;
          bus_data_d   = bif.m_data_i;
          bus_sel_d    = bif.m_sel_i;
        end
      end
      ST_BUS: begin
        // Ack is tested first so it wins over a same-cycle expiry.
        if (bif.bus_ack_i) begin
          bus_select_d = 1'b0;
          m_data_d     = bus_we_q ? '0 : bif.bus_data_i;
          m_ack_d      = 1'b1;
        end else if (expired) begin
          bus_select_d = 1'b0;
          m_data_d     = '0;
          m_ack_d      = 1'b1;
          m_err_d      = 1'b1;
          timeout_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus_select_q <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_data_q   <= '0;
      bus_sel_q    <= '0;
      m_data_q     <= '0;
      m_ack_q      <= 1'b0;
      m_err_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      bus_select_q <= bus_select_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_data_q   <= bus_data_d;
      bus_sel_q    <= bus_sel_d;
      m_data_q     <= m_data_d;
      m_ack_q      <= m_ack_d;
      m_err_q      <= m_err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bif.bus_select_o = bus_select_q;
  assign bif.bus_we_o     = bus_we_q;
  assign bif.bus_addr_o   = bus_addr_q;
  assign bif.bus_data_o   = bus_data_q;
  assign bif.bus_sel_o    = bus_sel_q;
  assign bif.m_data_o     = m_data_q;
  assign bif.m_ack_o      = m_ack_q;
  assign bif.m_err_o      = m_err_q;
  assign timeout_o        = timeout_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_bus_slave_bridge.sv
// tb_bus_slave_bridge
// Directed bench for bus_slave_bridge with three instances:
//   dut_a TIMEOUT=16, dut_b TIMEOUT=4, dut_c TIMEOUT=0.
// Inputs change 1ns after the rising edge; outputs are checked at that point.
module tb_bus_slave_bridge;
  import bus_slave_bridge_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  bus_slave_bridge_if #(.DATA_W(32), .ADDR_W(32)) ifa ();
  bus_slave_bridge_if #(.DATA_W(32), .ADDR_W(32)) ifb ();
  bus_slave_bridge_if #(.DATA_W(32), .ADDR_W(32)) ifc ();

  logic   to_a, to_b, to_c;
  state_t st_a, st_b, st_c;

  bus_slave_bridge #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .bif(ifa), .timeout_o(to_a), .state_o(st_a));
  bus_slave_bridge #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .bif(ifb), .timeout_o(to_b), .state_o(st_b));
  bus_slave_bridge #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(0)) dut_c (
    .clk_i(clk), .rst_i(rst), .bif(ifc), .timeout_o(to_c), .state_o(st_c));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    ifa.m_select_i = 0; ifa.m_we_i = 0; ifa.m_addr_i = 0; ifa.m_data_i = 0; ifa.m_sel_i = 0;
    ifa.bus_data_i = 0; ifa.bus_ack_i = 0;
    ifb.m_select_i = 0; ifb.m_we_i = 0; ifb.m_addr_i = 0; ifb.m_data_i = 0; ifb.m_sel_i = 0;
    ifb.bus_data_i = 0; ifb.bus_ack_i = 0;
    ifc.m_select_i = 0; ifc.m_we_i = 0; ifc.m_addr_i = 0; ifc.m_data_i = 0; ifc.m_sel_i = 0;
    ifc.bus_data_i = 0; ifc.bus_ack_i = 0;
    tick();
    tick();

    // Reset state
    check("rst_bus_select", 64'(ifa.bus_select_o), 64'd0);
    check("rst_m_ack",      64'(ifa.m_ack_o),      64'd0);
    check("rst_m_err",      64'(ifa.m_err_o),      64'd0);
    check("rst_m_data",     64'(ifa.m_data_o),     64'd0);
    check("rst_timeout",    64'(to_a),             64'd0);
    check("rst_state",      64'(st_a),             64'(ST_IDLE));
    rst = 1'b0;
    tick();

    // Read, TIMEOUT=16: accept c0, ack c3, m_ack c4
    ifa.m_select_i = 1; ifa.m_we_i = 0; ifa.m_addr_i = 32'h100; ifa.m_sel_i = 4'hF;
    tick();  // c1
    ifa.m_select_i = 0;
    check("rd_bus_select_c1", 64'(ifa.bus_select_o), 64'd1);
    check("rd_bus_addr",      64'(ifa.bus_addr_o),   64'h100);
    check("rd_bus_we",        64'(ifa.bus_we_o),     64'd0);
    check("rd_state_bus",     64'(st_a),             64'(ST_BUS));
    tick();  // c2
    tick();  // c3
    check("rd_bus_select_c3", 64'(ifa.bus_select_o), 64'd1);
    check("rd_no_ack_c3",     64'(ifa.m_ack_o),      64'd0);
    ifa.bus_ack_i = 1; ifa.bus_data_i = 32'hDEADBEEF;
    tick();  // c4
    ifa.bus_ack_i = 0; ifa.bus_data_i = 0;
    check("rd_ack_c4",        64'(ifa.m_ack_o),      64'd1);
    check("rd_data_c4",       64'(ifa.m_data_o),     64'hDEADBEEF);
    check("rd_err_c4",        64'(ifa.m_err_o),      64'd0);
    check("rd_bus_select_c4", 64'(ifa.bus_select_o), 64'd0);
    tick();  // c5
    check("rd_ack_c5",        64'(ifa.m_ack_o),      64'd0);
    check("rd_data_hold",     64'(ifa.m_data_o),     64'hDEADBEEF);
    check("rd_state_idle",    64'(st_a),             64'(ST_IDLE));

    // Ack while idle is ignored
    ifa.bus_ack_i = 1; ifa.bus_data_i = 32'h99999999;
    tick();
    tick();
    ifa.bus_ack_i = 0; ifa.bus_data_i = 0;
    check("idle_ack_ignored", 64'(ifa.m_ack_o),  64'd0);
    check("idle_data_hold",   64'(ifa.m_data_o), 64'hDEADBEEF);

    // Write, k=0: m_ack 2 cycles after accept, m_data 0
    ifa.m_select_i = 1; ifa.m_we_i = 1; ifa.m_addr_i = 32'h40;
    ifa.m_data_i = 32'h12345678; ifa.m_sel_i = 4'b0011;
    tick();  // c1
    ifa.m_select_i = 0; ifa.m_we_i = 0; ifa.m_addr_i = 0; ifa.m_data_i = 0; ifa.m_sel_i = 0;
    check("wr_bus_select", 64'(ifa.bus_select_o), 64'd1);
    check("wr_bus_we",     64'(ifa.bus_we_o),     64'd1);
    check("wr_bus_addr",   64'(ifa.bus_addr_o),   64'h40);
    check("wr_bus_data",   64'(ifa.bus_data_o),   64'h12345678);
    check("wr_bus_sel",    64'(ifa.bus_sel_o),    64'b0011);
    ifa.bus_ack_i = 1; ifa.bus_data_i = 32'hAAAA5555;
    tick();  // c2
    ifa.bus_ack_i = 0; ifa.bus_data_i = 0;
    check("wr_ack_c2",  64'(ifa.m_ack_o),  64'd1);
    check("wr_data_c2", 64'(ifa.m_data_o), 64'd0);
    check("wr_err_c2",  64'(ifa.m_err_o),  64'd0);
    tick();
    check("wr_ack_c3",  64'(ifa.m_ack_o),  64'd0);

    // Race, TIMEOUT=4: ack in 4th BUS cycle wins
    ifb.m_select_i = 1; ifb.m_addr_i = 32'h280;
    tick();  // c1
    ifb.m_select_i = 0;
    tick();  // c2
    tick();  // c3
    tick();  // c4
    check("race_bus_select_c4", 64'(ifb.bus_select_o), 64'd1);
    ifb.bus_ack_i = 1; ifb.bus_data_i = 32'hCAFEF00D;
    tick();  // c5
    ifb.bus_ack_i = 0; ifb.bus_data_i = 0;
    check("race_ack",     64'(ifb.m_ack_o),  64'd1);
    check("race_err",     64'(ifb.m_err_o),  64'd0);
    check("race_data",    64'(ifb.m_data_o), 64'hCAFEF00D);
    check("race_timeout", 64'(to_b),         64'd0);
    tick();

    // Timeout, TIMEOUT=4, no ack: bus_select high exactly 4 cycles
    ifb.m_select_i = 1; ifb.m_addr_i = 32'h200;
    tick();  // c1
    ifb.m_select_i = 0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_bus_select_c%0d", i + 1), 64'(ifb.bus_select_o), 64'd1);
      check($sformatf("to_no_ack_c%0d", i + 1),     64'(ifb.m_ack_o),      64'd0);
      tick();
    end
    // c5
    check("to_ack",        64'(ifb.m_ack_o),      64'd1);
    check("to_err",        64'(ifb.m_err_o),      64'd1);
    check("to_data",       64'(ifb.m_data_o),     64'd0);
    check("to_flag",       64'(to_b),             64'd1);
    check("to_bus_select", 64'(ifb.bus_select_o), 64'd0);
    tick();
    check("to_ack_after",  64'(ifb.m_ack_o), 64'd0);
    check("to_err_after",  64'(ifb.m_err_o), 64'd0);
    tick();
    tick();
    check("to_flag_sticky", 64'(to_b), 64'd1);

    // TIMEOUT=0: wait indefinitely
    ifc.m_select_i = 1; ifc.m_addr_i = 32'h600;
    tick();
    ifc.m_select_i = 0;
    for (int i = 0; i < 40; i++) tick();
    check("inf_bus_select", 64'(ifc.bus_select_o), 64'd1);
    check("inf_no_ack",     64'(ifc.m_ack_o),      64'd0);
    check("inf_no_timeout", 64'(to_c),             64'd0);
    ifc.bus_ack_i = 1; ifc.bus_data_i = 32'h5A5A5A5A;
    tick();
    ifc.bus_ack_i = 0; ifc.bus_data_i = 0;
    check("inf_ack",  64'(ifc.m_ack_o),  64'd1);
    check("inf_data", 64'(ifc.m_data_o), 64'h5A5A5A5A);
    check("inf_err",  64'(ifc.m_err_o),  64'd0);
    tick();

    // Reset in 2nd BUS cycle: asynchronous abort, no ack
    ifa.m_select_i = 1; ifa.m_addr_i = 32'h300;
    tick();  // c1
    ifa.m_select_i = 0;
    tick();  // c2
    check("rstmid_bus_select_pre", 64'(ifa.bus_select_o), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rstmid_bus_select_async", 64'(ifa.bus_select_o), 64'd0);
    check("rstmid_state",            64'(st_a),             64'(ST_IDLE));
    check("rstmid_timeout_clear",    64'(to_b),             64'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rstmid_no_ack_%0d", i), 64'(ifa.m_ack_o), 64'd0);
    end
    ifa.m_select_i = 1; ifa.m_addr_i = 32'h304;
    tick();  // c1
    ifa.m_select_i = 0;
    check("post_rst_bus_addr", 64'(ifa.bus_addr_o), 64'h304);
    tick();  // c2
    ifa.bus_ack_i = 1; ifa.bus_data_i = 32'h0BADF00D;
    tick();  // c3
    ifa.bus_ack_i = 0; ifa.bus_data_i = 0;
    check("post_rst_ack",  64'(ifa.m_ack_o),  64'd1);
    check("post_rst_data", 64'(ifa.m_data_o), 64'h0BADF00D);
    tick();

    // Back-to-back: select held through RESP, re-accepted in the next IDLE
    ifa.m_select_i = 1; ifa.m_addr_i = 32'h500;
    tick();  // c1 BUS
    ifa.bus_ack_i = 1; ifa.bus_data_i = 32'h11111111;
    tick();  // c2 RESP
    ifa.bus_ack_i = 0; ifa.bus_data_i = 0; ifa.m_addr_i = 32'h504;
    check("b2b_ack1",        64'(ifa.m_ack_o),      64'd1);
    check("b2b_data1",       64'(ifa.m_data_o),     64'h11111111);
    check("b2b_gap_resp",    64'(ifa.bus_select_o), 64'd0);
    tick();  // c3 IDLE
    check("b2b_gap_idle",    64'(ifa.bus_select_o), 64'd0);
    check("b2b_state_idle",  64'(st_a),             64'(ST_IDLE));
    check("b2b_ack_gap",     64'(ifa.m_ack_o),      64'd0);
    tick();  // c4 BUS
    ifa.m_select_i = 0;
    check("b2b_bus_select2", 64'(ifa.bus_select_o), 64'd1);
    check("b2b_bus_addr2",   64'(ifa.bus_addr_o),   64'h504);
    ifa.bus_ack_i = 1; ifa.bus_data_i = 32'h22222222;
    tick();  // c5 RESP
    ifa.bus_ack_i = 0; ifa.bus_data_i = 0;
    check("b2b_ack2",        64'(ifa.m_ack_o),  64'd1);
    check("b2b_data2",       64'(ifa.m_data_o), 64'h22222222);
    tick();  // c6
    check("b2b_end_select",  64'(ifa.bus_select_o), 64'd0);
    check("b2b_end_ack",     64'(ifa.m_ack_o),      64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
